// File: rtl/bcd4_to_bin_pkg.sv
// ---------------------------------------------------------------------------
// bcd4_to_bin_pkg
//
// Purpose:
//   Shared constants, state encoding and small arithmetic helpers for the
//   four-digit BCD to binary converter.  The forward converter (bcd4digit)
//   imports the same package, so both directions agree on digit width,
//   result width and the largest legal BCD digit.
//
// Contents:
//   DIGIT_W    width of one BCD digit
//   VALUE_W    width of the binary result / accumulator
//   NDIGITS    number of BCD digits converted
//   BCD_MAX    largest legal BCD digit value
//   IDX_W      width of the digit index
//   state_t    converter FSM states IDLE, X5, X2, DONE
//   times5     acc*5 built from a shift and an add
//   times2_add acc*2 + digit built from a shift and an add
// ---------------------------------------------------------------------------
package bcd4_to_bin_pkg;

    localparam int DIGIT_W = 4;
    localparam int VALUE_W = 14;
    localparam int NDIGITS = 4;
    localparam int BCD_MAX = 9;
    localparam int IDX_W   = 2;

    // Sized copies so comparisons and index tests need no width casts.
    localparam logic [DIGIT_W-1:0] BCD_MAX_D = DIGIT_W'(BCD_MAX);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        X5   = 2'd1,
        X2   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Multiply by five as (acc << 2) + acc; the result wraps at VALUE_W bits.
    function automatic logic [VALUE_W-1:0] times5(input logic [VALUE_W-1:0] acc);
        logic [VALUE_W-1:0] shifted;
        shifted = acc << 2;
        return shifted + acc;
    endfunction

    // Multiply by two and add a zero-extended digit; wraps at VALUE_W bits.
    function automatic logic [VALUE_W-1:0] times2_add(
        input logic [VALUE_W-1:0] acc,
        input logic [DIGIT_W-1:0] digit
    );
        logic [VALUE_W-1:0] shifted;
        logic [VALUE_W-1:0] digit_ext;
        shifted   = acc << 1;
        digit_ext = {{(VALUE_W - DIGIT_W){1'b0}}, digit};
        return shifted + digit_ext;
    endfunction

endpackage

// File: rtl/bcd4_to_bin_digit_valid.sv
// ---------------------------------------------------------------------------
// bcd_digit_valid
//
// Purpose:
//   Purely combinational check that a four-bit value is a legal BCD digit
//   (0..9).  The converter instantiates one per input digit.
//
// Ports:
//   digit  in  DIGIT_W  candidate BCD digit
//   valid  out 1        high when digit <= BCD_MAX
// ---------------------------------------------------------------------------
module bcd_digit_valid
    import bcd4_to_bin_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic               valid
);

    assign valid = (digit <= BCD_MAX_D);

endmodule

// File: rtl/bcd4_to_bin.sv
// ---------------------------------------------------------------------------
// bcd4_to_bin
//
// Purpose:
//   Converts four BCD digits (A = thousands .. D = units) into a 14-bit
//   binary value with a fixed eight-cycle latency.  Each digit costs two
//   cycles: X5 multiplies the accumulator by five, X2 doubles it and adds
//   the next digit, which together form acc*10 + digit using only shifts
//   and adds.  Digits are captured when start is accepted so later input
//   changes cannot disturb a running conversion.
//
// Ports:
//   clk    in  1   rising-edge clock
//   rst    in  1   asynchronous active-high reset
//   start  in  1   single-cycle conversion request (accepted in IDLE/DONE)
//   A      in  4   BCD thousands digit
//   B      in  4   BCD hundreds digit
//   C      in  4   BCD tens digit
//   D      in  4   BCD units digit
//   value  out 14  binary result, registered, held in DONE
//   ready  out 1   result valid, registered
//   busy   out 1   conversion in progress, registered
//   err    out 1   last accepted input held a digit > 9, registered
// ---------------------------------------------------------------------------
module bcd4_to_bin
    import bcd4_to_bin_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIGIT_W-1:0] A,
    input  logic [DIGIT_W-1:0] B,
    input  logic [DIGIT_W-1:0] C,
    input  logic [DIGIT_W-1:0] D,
    output logic [VALUE_W-1:0] value,
    output logic               ready,
    output logic               busy,
    output logic               err
);

    // FSM state and datapath registers with their next-state values.
    state_t                     state_q, state_d;
    logic [VALUE_W-1:0]         acc_q, acc_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DIGIT_W-1:0]         dig_a_q, dig_a_d;
    logic [DIGIT_W-1:0]         dig_b_q, dig_b_d;
    logic [DIGIT_W-1:0]         dig_c_q, dig_c_d;
    logic [DIGIT_W-1:0]         dig_d_q, dig_d_d;
    logic [VALUE_W-1:0]         value_q, value_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;

    // Validity of the live input digits, evaluated at the accept edge.
    logic [NDIGITS-1:0]         digit_ok;
    logic                       any_bad;

    // Digit chosen by the current index and the X2 step result.
    logic [DIGIT_W-1:0]         cur_digit;
    logic [VALUE_W-1:0]         acc_x2;

    bcd_digit_valid u_valid_a (.digit(A), .valid(digit_ok[0]));
    bcd_digit_valid u_valid_b (.digit(B), .valid(digit_ok[1]));
    bcd_digit_valid u_valid_c (.digit(C), .valid(digit_ok[2]));
    bcd_digit_valid u_valid_d (.digit(D), .valid(digit_ok[3]));

    assign any_bad = ~(&digit_ok);

    // Index 0 selects the most significant digit so that repeated
    // acc*10 + digit builds the number from the thousands digit downwards.
    always_comb begin
        cur_digit = dig_a_q;
        case (idx_q)
            2'd0:    cur_digit = dig_a_q;
            2'd1:    cur_digit = dig_b_q;
            2'd2:    cur_digit = dig_c_q;
            default: cur_digit = dig_d_q;
        endcase
    end

    assign acc_x2 = times2_add(acc_q, cur_digit);

    // Next-state and output logic.  Everything holds by default; start is
    // only honoured in IDLE and DONE, so a request while busy is dropped.
    // Leaving X2 on the last digit loads value, raises ready and drops busy
    // on one edge, which keeps ready and busy mutually exclusive.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        dig_a_d = dig_a_q;
        dig_b_d = dig_b_q;
        dig_c_d = dig_c_q;
        dig_d_d = dig_d_q;
        value_d = value_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dig_a_d = A;
                    dig_b_d = B;
                    dig_c_d = C;
                    dig_d_d = D;
                    acc_d   = '0;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = any_bad;
                    state_d = X5;
                end
            end

            X5: begin
                acc_d   = times5(acc_q);
                state_d = X2;
            end

            X2: begin
                acc_d = acc_x2;
                if (idx_q == LAST_IDX) begin
                    // An invalid input reports zero rather than a
                    // meaningless partial conversion.
                    value_d = err_q ? '0 : acc_x2;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = X5;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            dig_a_q <= '0;
            dig_b_q <= '0;
            dig_c_q <= '0;
            dig_d_q <= '0;
            value_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            dig_a_q <= dig_a_d;
            dig_b_q <= dig_b_d;
            dig_c_q <= dig_c_d;
            dig_d_q <= dig_d_d;
            value_q <= value_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign value = value_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd4_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd4_to_bin
//
// Purpose:
//   Directed self-checking bench for bcd4_to_bin.  Inputs change just after
//   falling edges and outputs are sampled on falling edges, half a cycle
//   away from the active rising edge.  Edge N is the rising edge that
//   samples start; "after edge N+k" is the falling edge that follows it.
// ---------------------------------------------------------------------------
module tb_bcd4_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  A, B, C, D;
    logic [13:0] value;
    logic        ready;
    logic        busy;
    logic        err;

    int pass_cnt;
    int total_cnt;

    bcd4_to_bin dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .value (value),
        .ready (ready),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything ever stalls the sequence below.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present digits with start for one rising edge; returns at the falling
    // edge after that edge (after edge N) with start low again.
    task automatic pulse_start(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        @(negedge clk);
        start = 1'b1;
        A = a; B = b; C = c; D = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
        #1;
        total_cnt++;
        if ({value, ready, busy, err} !== 17'd0)
            $display("[TB] FAIL reset_outputs: got value=%0d ready=%b busy=%b err=%b required all 0",
                     value, ready, busy, err);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({value, ready, busy, err} !== 17'd0)
            $display("[TB] FAIL reset_release_idle: got value=%0d ready=%b busy=%b err=%b required all 0",
                     value, ready, busy, err);
        else pass_cnt++;
    endtask

    // 4934: eight busy cycles, ready exactly after edge N+8.
    task automatic test_basic();
        int busy_cycles;
        busy_cycles = 0;
        pulse_start(4'd4, 4'd9, 4'd3, 4'd4);
        if (busy) busy_cycles++;
        total_cnt++;
        if ({busy, ready, err} !== 3'b100)
            $display("[TB] FAIL basic_accept: got busy/ready/err=%b required 100", {busy, ready, err});
        else pass_cnt++;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (k == 7) begin
                total_cnt++;
                if ({busy, ready} !== 2'b10)
                    $display("[TB] FAIL basic_n7_not_ready: got busy/ready=%b required 10", {busy, ready});
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({busy, ready, err} !== 3'b010 || value !== 14'd4934)
            $display("[TB] FAIL basic_4934: got value=%0d busy/ready/err=%b required 4934 010",
                     value, {busy, ready, err});
        else pass_cnt++;
        total_cnt++;
        if (busy_cycles !== 8)
            $display("[TB] FAIL basic_busy_len: got %0d cycles required 8", busy_cycles);
        else pass_cnt++;
        // Result must hold while the block sits in DONE.
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, ready, err} !== 3'b010 || value !== 14'd4934)
            $display("[TB] FAIL basic_hold: got value=%0d busy/ready/err=%b required 4934 010",
                     value, {busy, ready, err});
        else pass_cnt++;
    endtask

    // Largest and smallest legal inputs.
    task automatic test_extremes();
        pulse_start(4'd9, 4'd9, 4'd9, 4'd9);
        repeat (8) @(negedge clk);
        total_cnt++;
        if (value !== 14'h270F || {ready, err} !== 2'b10)
            $display("[TB] FAIL max_9999: got value=%0d ready/err=%b required 9999 10", value, {ready, err});
        else pass_cnt++;
        pulse_start(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (8) @(negedge clk);
        total_cnt++;
        if (value !== 14'd0 || {ready, err} !== 2'b10)
            $display("[TB] FAIL min_0000: got value=%0d ready/err=%b required 0 10", value, {ready, err});
        else pass_cnt++;
    endtask

    // Digit 0xA flags err and forces value to zero; next valid input clears it.
    task automatic test_invalid();
        pulse_start(4'd1, 4'd2, 4'hA, 4'd4);
        total_cnt++;
        if (err !== 1'b1)
            $display("[TB] FAIL invalid_err_on_accept: got err=%b required 1", err);
        else pass_cnt++;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (value !== 14'd0 || {ready, busy, err} !== 3'b101)
            $display("[TB] FAIL invalid_result: got value=%0d ready/busy/err=%b required 0 101",
                     value, {ready, busy, err});
        else pass_cnt++;
        pulse_start(4'd0, 4'd0, 4'd0, 4'd7);
        repeat (8) @(negedge clk);
        total_cnt++;
        if (value !== 14'd7 || {ready, busy, err} !== 3'b100)
            $display("[TB] FAIL invalid_recover_7: got value=%0d ready/busy/err=%b required 7 100",
                     value, {ready, busy, err});
        else pass_cnt++;
    endtask

    // Inputs change after the start edge and a second start arrives at N+3.
    task automatic test_ignore_start();
        pulse_start(4'd1, 4'd2, 4'd3, 4'd4);
        A = 4'd9; B = 4'd9; C = 4'd9; D = 4'd9;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) begin
                start = 1'b1;
                A = 4'd5; B = 4'd6; C = 4'd7; D = 4'd8;
            end
            if (k == 3) begin
                start = 1'b0;
                total_cnt++;
                if ({busy, ready} !== 2'b10)
                    $display("[TB] FAIL ignore_busy_n3: got busy/ready=%b required 10", {busy, ready});
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (value !== 14'd1234 || {ready, busy, err} !== 3'b100)
            $display("[TB] FAIL ignore_1234: got value=%0d ready/busy/err=%b required 1234 100",
                     value, {ready, busy, err});
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (value !== 14'd1234 || {ready, busy} !== 2'b10)
            $display("[TB] FAIL ignore_no_restart: got value=%0d ready/busy=%b required 1234 10",
                     value, {ready, busy});
        else pass_cnt++;
    endtask

    // Reset mid-conversion clears outputs asynchronously; the first edge
    // after release accepts a new start.
    task automatic test_reset_abort();
        pulse_start(4'd4, 4'd9, 4'd3, 4'd4);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({value, ready, busy, err} !== 17'd0)
            $display("[TB] FAIL abort_async_clear: got value=%0d ready=%b busy=%b err=%b required all 0",
                     value, ready, busy, err);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        A = 4'd0; B = 4'd0; C = 4'd4; D = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if ({busy, ready} !== 2'b10)
            $display("[TB] FAIL abort_first_edge_accept: got busy/ready=%b required 10", {busy, ready});
        else pass_cnt++;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (value !== 14'd42 || {ready, busy, err} !== 3'b100)
            $display("[TB] FAIL abort_then_42: got value=%0d ready/busy/err=%b required 42 100",
                     value, {ready, busy, err});
        else pass_cnt++;
    endtask

    // Start from DONE: ready drops after that edge and returns 8 edges later.
    task automatic test_back_to_back();
        pulse_start(4'd8, 4'd0, 4'd0, 4'd1);
        total_cnt++;
        if ({ready, busy} !== 2'b01)
            $display("[TB] FAIL b2b_ready_drop: got ready/busy=%b required 01", {ready, busy});
        else pass_cnt++;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8 && ready && busy) begin
                total_cnt++;
                $display("[TB] FAIL b2b_exclusive: got ready=1 busy=1 required not both at edge N+%0d", k);
            end
        end
        total_cnt++;
        if (value !== 14'd8001 || {ready, busy, err} !== 3'b100)
            $display("[TB] FAIL b2b_8001: got value=%0d ready/busy/err=%b required 8001 100",
                     value, {ready, busy, err});
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_invalid();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bcd4_to_bin.md
BCD4_TO_BIN -- requirements
Module: bcd4_to_bin

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-002 Port list, clock and reset first: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 start  in  1  single-cycle conversion request.
REQ-005 A  in  4  BCD thousands digit.
REQ-006 B  in  4  BCD hundreds digit.
REQ-007 C  in  4  BCD tens digit.
REQ-008 D  in  4  BCD units digit.
REQ-009 value  out  14  binary result, registered.
REQ-010 ready  out  1  result valid, registered.
REQ-011 busy  out  1  conversion in progress, registered.
REQ-012 err  out  1  last accepted input held a digit > 9, registered.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, X5, X2, DONE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted on that clock edge: latch A..D, clear acc to 0 and the 2-bit digit index to 0, clear ready, set busy, set err if any digit > 9, and go to X5.
REQ-015 In X5, the block SHALL compute acc = (acc<<2) + acc, then go to X2.
REQ-016 In X2, the block SHALL compute acc = (acc<<1) + digit[index], where index 0..3 selects A, B, C, D; it SHALL then increment index and go to X5, or go to DONE when index = 3.
REQ-017 The datapath SHALL be a 14-bit acc; intermediate results SHALL wrap modulo 2^14, and valid inputs (max 9999) SHALL never wrap.
REQ-018 On entry to DONE, the block SHALL load value with acc (or 0 if err=1), set ready=1 and clear busy, all on the same edge.
REQ-019 Latency SHALL be fixed: start sampled at edge N gives ready=1 and a valid value after edge N+8.
REQ-020 value, ready and err SHALL hold in DONE until the next accepted start.
REQ-021 start while busy=1 (X5/X2) SHALL be ignored, with no effect on the latched digits or the result.
REQ-022 A..D changing after the start edge SHALL NOT affect the result.
REQ-023 start in DONE SHALL begin a new conversion on that edge; ready SHALL drop after the same edge.
REQ-024 busy and ready SHALL never both be 1.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, value=0, ready=0, busy=0, err=0, acc=0 and index=0.
REQ-026 rst asserted mid-conversion SHALL abort it with no result, and the next start after deassertion SHALL be processed normally.
REQ-027 The first rising edge with rst=0 SHALL be able to accept start.

Structure
REQ-028 A shared package/include SHALL hold the state encodings (IDLE, X5, X2, DONE), DIGIT_W=4, VALUE_W=14, NDIGITS=4 and BCD_MAX=9; bcd4digit (the forward converter) SHALL use the same constants.
REQ-029 The block SHALL have one sub-module, bcd_digit_valid: combinational, 4-bit digit in, valid out (digit <= 9), instantiated four times.
REQ-030 The block SHALL have no other sub-modules, and no multiplier or divider inferred (shift-add only).

Verification
REQ-031 A=4,B=9,C=3,D=4, start one cycle -> ready after edge N+8, value=4934, err=0, busy high for exactly 8 cycles.
REQ-032 Digits 9,9,9,9 -> value=9999 (14'h270F); digits 0,0,0,0 -> value=0; both err=0.
REQ-033 Digits 1,2,0xA,4 -> after N+8: ready=1, err=1, value=0; a following conversion of 0,0,0,7 -> err=0, value=7.
REQ-034 Convert 1234; pulse start with 5,6,7,8 at edge N+3 and change A..D at N+1 -> value=1234 at N+8, second start ignored.
REQ-035 Assert rst at N+4 of a conversion of 4934 -> outputs 0 immediately (asynchronously); after release, convert 0042 -> value=42 at +8 edges.
REQ-036 Back-to-back: start in DONE with 8,0,0,1 -> ready falls after the start edge and rises 8 edges later with value=8001.
